seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential unsigned ALU. ADD/SUB/MUL complete in one cycle;
// DIV/MOD use a restoring divider that produces one quotient bit per cycle.
`default_nettype none

module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           mode_select,
    output logic                 ready,
    output logic                 valid,
    output logic [2*WIDTH-1:0]   c,
    output logic                 err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nx;

    logic [WIDTH-1:0]     r_quo;
    logic [WIDTH-1:0]     r_rem;
    logic [WIDTH-1:0]     r_div;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_is_mod;
    logic [2*WIDTH-1:0]   r_c;
    logic                 r_err;

    logic                 w_accept;
    logic                 w_is_div;
    logic                 w_b_zero;
    logic                 w_long_op;
    logic                 w_last_iter;
    logic [2*WIDTH-1:0]   w_a_ext;
    logic [2*WIDTH-1:0]   w_b_ext;
    logic [2*WIDTH-1:0]   w_quick_c;
    logic                 w_quick_err;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_trial;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_rem_nx;
    logic [WIDTH-1:0]     w_quo_nx;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_is_div    = (mode_select == OP_DIV) || (mode_select == OP_MOD);
    assign w_b_zero    = (b == '0);
    assign w_long_op   = w_is_div && !w_b_zero;
    assign w_last_iter = (r_cnt == CNT_W'(1));
    assign w_a_ext     = {{WIDTH{1'b0}}, a};
    assign w_b_ext     = {{WIDTH{1'b0}}, b};

    // Single-cycle results, including the divide-by-zero and illegal-opcode cases.
    always_comb begin
        w_quick_c   = '0;
        w_quick_err = 1'b0;
        case (mode_select)
            OP_ADD: w_quick_c = w_a_ext + w_b_ext;
            OP_SUB: w_quick_c = {{WIDTH{1'b0}}, a - b};
            OP_MUL: w_quick_c = w_a_ext * w_b_ext;
            OP_DIV: begin
                w_quick_c   = '1;
                w_quick_err = 1'b1;
            end
            OP_MOD: begin
                w_quick_c   = w_a_ext;
                w_quick_err = 1'b1;
            end
            default: begin
                w_quick_c   = '0;
                w_quick_err = 1'b1;
            end
        endcase
    end

    // Remainder stays below the divisor, so the shifted trial never exceeds 2*div-1
    // and the MSB of the difference is a clean borrow flag.
    assign w_rem_sh = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_div};
    assign w_ge     = ~w_trial[WIDTH];
    assign w_rem_nx = w_ge ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
    assign w_quo_nx = {r_quo[WIDTH-2:0], w_ge};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx = w_long_op ? S_BUSY : S_DONE;
                end
            end
            S_BUSY: begin
                if (w_last_iter) begin
                    w_state_nx = S_DONE;
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_cnt    <= '0;
            r_is_mod <= 1'b0;
            r_c      <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_quo    <= a;
            r_rem    <= '0;
            r_div    <= b;
            r_cnt    <= CNT_W'(WIDTH);
            r_is_mod <= (mode_select == OP_MOD);
            if (!w_long_op) begin
                r_c   <= w_quick_c;
                r_err <= w_quick_err;
            end
        end else if (r_state == S_BUSY) begin
            r_rem <= w_rem_nx;
            r_quo <= w_quo_nx;
            r_cnt <= r_cnt - CNT_W'(1);
            if (w_last_iter) begin
                r_c   <= r_is_mod ? {{WIDTH{1'b0}}, w_rem_nx} : {{WIDTH{1'b0}}, w_quo_nx};
                r_err <= 1'b0;
            end
        end
    end

    assign ready = (r_state == S_IDLE);
    assign valid = (r_state == S_DONE);
    assign c     = r_c;
    assign err   = r_err;

endmodule

`default_nettype wire
